bitmap_line_fetcher: RTL and testbench

BITMAP_LINE_FETCHER -- requirements
Module: bitmap_line_fetcher

---
 rtl/bitmap_fetch_pkg.sv | 34 +++
 rtl/bde_fetch_fifo.sv | 64 ++++++
 rtl/bitmap_line_fetcher.sv | 221 ++++++++++++++++++++++
 tb/tb_bitmap_line_fetcher.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitmap_fetch_pkg.sv
// Shared definitions for the bitmap line fetcher.
// Holds the request FSM encoding, the read-command payload, the beat size,
// and the helpers that turn a frame geometry into beat and burst counts.
package bitmap_fetch_pkg;

  localparam int unsigned BYTES_PER_BEAT = 8;
  localparam int unsigned PIX_PER_BEAT   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    REQ   = 2'd2,
    DATA  = 2'd3
  } fetch_state_t;

  // Read command presented to the AXI read master
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } bde_cmd_t;

  // 64-bit beats needed for a frame of 32-bit pixels
  function automatic int unsigned frame_words(input int unsigned h_pixels,
                                              input int unsigned v_lines);
    return (h_pixels * v_lines) / PIX_PER_BEAT;
  endfunction

  // Read bursts needed for a frame
  function automatic int unsigned frame_bursts(input int unsigned words,
                                               input int unsigned burst_beats);
    return words / burst_beats;
  endfunction

endpackage

// File: rtl/bde_fetch_fifo.sv
// Synchronous FIFO buffering read beats ahead of the pixel unpacker.
// Ports: clk, rst_n (sync active-low); wr_en/wr_data write side;
// rd_en pops the head word shown on rd_data_c (first-word fall-through);
// count is the registered occupancy; empty_c flags no data;
// wr_drop_c flags a write attempted while full (the beat is dropped).
module bde_fetch_fifo
  import bitmap_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty_c,
  output logic                     wr_drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full_c;
  logic             wr_ok;
  logic             rd_ok;

  assign full_c    = (count == CW'(DEPTH));
  assign empty_c   = (count == '0);
  assign wr_ok     = wr_en && !full_c;
  assign rd_ok     = rd_en && !empty_c;
  assign wr_drop_c = wr_en && full_c;
  assign rd_data_c = mem[rd_ptr];

  // Storage array, no reset needed on data
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bitmap_line_fetcher.sv
// Frame-buffer fetcher: reads a whole frame from memory in fixed-size
// bursts through a simple request/ack read master, buffers the beats and
// streams them out as 32-bit pixels (low half of each beat first).
// Ports: ACLK/ARESETN (sync active-low); start/frame_base begin a frame;
// busy/frame_done report progress; bde_* is the read-master interface;
// pix_data/pix_valid/pix_ready is the pixel stream; underflow is a sticky
// flag for a consumer that was ready while no pixel was available.
module bitmap_line_fetcher
  import bitmap_fetch_pkg::*;
#(
  parameter int unsigned H_PIXELS    = 800,
  parameter int unsigned V_LINES     = 600,
  parameter int unsigned BURST_BEATS = 16,
  parameter int unsigned FIFO_DEPTH  = 64
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  input  logic [31:0] frame_base,
  output logic        busy,
  output logic        frame_done,
  output logic        bde_req,
  input  logic        bde_ack,
  output logic [7:0]  bde_arlen,
  output logic [31:0] bde_address,
  input  logic [63:0] bde_data_in,
  input  logic        bde_data_valid,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        underflow
);

  localparam int unsigned WORDS       = frame_words(H_PIXELS, V_LINES);
  localparam int unsigned BURSTS      = frame_bursts(WORDS, BURST_BEATS);
  localparam int unsigned TOTAL_PIX   = H_PIXELS * V_LINES;
  localparam int unsigned BURST_BYTES = BURST_BEATS * BYTES_PER_BEAT;
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BEAT_W      = 9;

  // Elaboration-time geometry checks
  if (BURST_BEATS < 1 || BURST_BEATS > 256) begin : g_bad_burst
    $error("BURST_BEATS must be in 1..256");
  end
  if (WORDS * PIX_PER_BEAT != TOTAL_PIX) begin : g_bad_words
    $error("H_PIXELS*V_LINES must be even");
  end
  if (BURSTS * BURST_BEATS != WORDS) begin : g_bad_bursts
    $error("frame words must be a multiple of BURST_BEATS");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2 * BURST_BEATS) begin : g_bad_fifo
    $error("FIFO_DEPTH must be a power of two and >= 2*BURST_BEATS");
  end

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  bde_cmd_t           cmd;
  logic [31:0]        burst_cnt;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0]  discard_cnt;
  logic [BEAT_W-1:0]  stale_beats;
  logic [31:0]        pix_cnt;
  logic               half;
  logic               ovf_err;

  logic               start_ok;
  logic               beat_in;
  logic               discard_dec;
  logic               last_beat;
  logic               last_burst;
  logic               space_ok;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   fifo_free;
  logic [63:0]        fifo_head;
  logic               fifo_empty;
  logic               fifo_drop;
  logic               fifo_rd;
  logic               pix_load;
  logic               pix_hs;

  // A start coinciding with frame_done, or while the previous frame is
  // still draining, is ignored.
  assign start_ok    = start && (state == IDLE) && !busy && !frame_done;
  assign beat_in     = bde_data_valid && (discard_cnt == '0);
  assign discard_dec = bde_data_valid && (discard_cnt != '0);
  assign last_beat   = (state == DATA) && beat_in &&
                       (beat_cnt == BEAT_W'(BURST_BEATS - 1));
  assign last_burst  = (burst_cnt == 32'(BURSTS - 1));
  assign fifo_free   = CNT_W'(FIFO_DEPTH) - fifo_count;
  assign space_ok    = (fifo_free >= CNT_W'(BURST_BEATS)) && (discard_cnt == '0);

  assign bde_address = cmd.addr;
  assign bde_arlen   = cmd.len;

  // Next-state logic for the burst request FSM
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = CHECK;
      CHECK:   if (space_ok) state_nxt = REQ;
      REQ:     if (bde_ack)  state_nxt = DATA;
      DATA:    if (last_beat) state_nxt = last_burst ? IDLE : CHECK;
      default: state_nxt = IDLE;
    endcase
  end

  // Beats still owed by a burst that a reset interrupts; they must be
  // swallowed before the next request so they never reach the FIFO.
  always_comb begin
    stale_beats = discard_cnt - BEAT_W'(discard_dec);
    if (state == DATA) begin
      stale_beats = BEAT_W'(BURST_BEATS) - beat_cnt - BEAT_W'(bde_data_valid);
    end else if (state == REQ && bde_ack) begin
      stale_beats = BEAT_W'(BURST_BEATS);
    end
  end

  // Request side: FSM state, command registers, burst and beat counters.
  // The address advances as a burst completes, so it is already stable in
  // CHECK, one cycle before bde_req rises.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state       <= IDLE;
      bde_req     <= 1'b0;
      cmd         <= '0;
      burst_cnt   <= '0;
      beat_cnt    <= '0;
      discard_cnt <= stale_beats;
    end else begin
      state   <= state_nxt;
      bde_req <= (state_nxt == REQ);
      if (start_ok) begin
        cmd.addr  <= frame_base;
        cmd.len   <= 8'(BURST_BEATS - 1);
        burst_cnt <= '0;
      end else if (last_beat) begin
        cmd.addr  <= cmd.addr + 32'(BURST_BYTES);
        burst_cnt <= burst_cnt + 32'd1;
      end
      if (state == REQ && bde_ack) begin
        beat_cnt <= '0;
      end else if (state == DATA && beat_in) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
      if (discard_dec) begin
        discard_cnt <= discard_cnt - BEAT_W'(1);
      end
    end
  end

  bde_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .wr_en     (beat_in),
    .wr_data   (bde_data_in),
    .rd_en     (fifo_rd),
    .rd_data_c (fifo_head),
    .count     (fifo_count),
    .empty_c   (fifo_empty),
    .wr_drop_c (fifo_drop)
  );

  // Output register loads whenever it is empty or being consumed; the FIFO
  // word is popped only after its upper pixel has been taken.
  assign pix_load = (!pix_valid || pix_ready) && !fifo_empty;
  assign fifo_rd  = pix_load && half;
  assign pix_hs   = pix_valid && pix_ready;

  // Pixel output stage
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      half      <= 1'b0;
    end else if (pix_load) begin
      pix_valid <= 1'b1;
      pix_data  <= half ? fifo_head[63:32] : fifo_head[31:0];
      half      <= ~half;
    end else if (pix_ready) begin
      pix_valid <= 1'b0;
    end
  end

  // Frame progress, completion pulse and sticky error flags
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pix_cnt    <= '0;
      underflow  <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start_ok) begin
        busy      <= 1'b1;
        pix_cnt   <= '0;
        underflow <= 1'b0;
      end else begin
        if (pix_hs && busy) begin
          if (pix_cnt == 32'(TOTAL_PIX - 1)) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            pix_cnt    <= '0;
          end else begin
            pix_cnt <= pix_cnt + 32'd1;
          end
        end
        if (pix_ready && !pix_valid && busy) begin
          underflow <= 1'b1;
        end
      end
      if (fifo_drop) begin
        ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bitmap_line_fetcher.sv
// Self-checking bench for bitmap_line_fetcher: a behavioural read slave
// returns beats whose pixel halves equal their own byte address, so every
// expected pixel is frame_base + 4*n.
module tb_bitmap_line_fetcher;

  localparam int unsigned H      = 32;
  localparam int unsigned V      = 8;
  localparam int unsigned BB     = 16;
  localparam int unsigned FD     = 64;
  localparam int unsigned NPIX   = H * V;
  localparam int unsigned NBURST = (H * V / 2) / BB;
  localparam int          TMO    = 20000;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        main_rstn;
  logic        slave_rst;
  logic        start;
  logic [31:0] frame_base;
  logic        busy;
  logic        frame_done;
  logic        bde_req;
  logic        bde_ack;
  logic [7:0]  bde_arlen;
  logic [31:0] bde_address;
  logic [63:0] bde_data_in;
  logic        bde_data_valid;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        underflow;

  assign ARESETN = main_rstn & ~slave_rst;

  bitmap_line_fetcher #(
    .H_PIXELS    (H),
    .V_LINES     (V),
    .BURST_BEATS (BB),
    .FIFO_DEPTH  (FD)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .start          (start),
    .frame_base     (frame_base),
    .busy           (busy),
    .frame_done     (frame_done),
    .bde_req        (bde_req),
    .bde_ack        (bde_ack),
    .bde_arlen      (bde_arlen),
    .bde_address    (bde_address),
    .bde_data_in    (bde_data_in),
    .bde_data_valid (bde_data_valid),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .underflow      (underflow)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ready_mode = 0;   // 0 always ready, 1 never, 2 toggle, 3 random
  int gap = 0;          // idle cycles between beats
  bit rst_arm = 1'b0;   // slave pulses reset at beat 5 of a burst
  int rst_fired = 0;
  int bursts_seen = 0;
  int done_cnt = 0;
  int done_before = 0;
  logic [31:0] exp_pix[$];
  logic [31:0] exp_addr[$];
  int beat0_cyc[$];
  int rise_cyc[$];

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Read slave: ack one cycle after seeing bde_req, first beat 3 cycles later
  initial begin : slave
    logic [31:0] a;
    bde_ack = 1'b0;
    bde_data_valid = 1'b0;
    bde_data_in = '0;
    slave_rst = 1'b0;
    forever begin
      @(negedge ACLK);
      if (bde_req === 1'b1) begin
        if (exp_addr.size() == 0) check_val("addr_unexpected", 64'(exp_addr.size()), 64'd1);
        else check_val("burst_addr", 64'(bde_address), 64'(exp_addr.pop_front()));
        check_val("burst_arlen", 64'(bde_arlen), 64'(BB - 1));
        bursts_seen++;
        a = bde_address;
        bde_ack = 1'b1;
        @(negedge ACLK);
        bde_ack = 1'b0;
        repeat (2) @(negedge ACLK);
        for (int b = 0; b < int'(BB); b++) begin
          bde_data_valid = 1'b1;
          bde_data_in = {a + 32'd4, a};
          a = a + 32'd8;
          if (b == 0) beat0_cyc.push_back(cyc);
          if (rst_arm && b == 5) begin
            slave_rst = 1'b1;
            rst_fired++;
          end
          check_val("one_outstanding", 64'(bde_req), 64'd0);
          @(negedge ACLK);
          bde_data_valid = 1'b0;
          slave_rst = 1'b0;
          repeat (gap) @(negedge ACLK);
        end
      end
    end
  end

  // Pixel consumer and scoreboard
  initial begin : consumer
    logic [31:0] held;
    bit stalled;
    bit prev_valid;
    stalled = 1'b0;
    prev_valid = 1'b0;
    held = '0;
    pix_ready = 1'b0;
    forever begin
      @(negedge ACLK);
      if (stalled && ARESETN === 1'b1) begin
        check_val("stall_valid_held", 64'(pix_valid), 64'd1);
        check_val("stall_data_stable", 64'(pix_data), 64'(held));
      end
      case (ready_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = 1'b0;
        2:       pix_ready = ~pix_ready;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      if (pix_valid === 1'b1 && !prev_valid) rise_cyc.push_back(cyc);
      prev_valid = (pix_valid === 1'b1);
      if (pix_valid === 1'b1 && pix_ready) begin
        if (exp_pix.size() == 0) check_val("pix_unexpected", 64'(exp_pix.size()), 64'd1);
        else check_val("pix_data", 64'(pix_data), 64'(exp_pix.pop_front()));
      end
      stalled = (pix_valid === 1'b1) && !pix_ready;
      held = pix_data;
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge ACLK);
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  task automatic do_start(input logic [31:0] base);
    for (int k = 0; k < int'(NBURST); k++) exp_addr.push_back(base + 32'(k * BB * 8));
    for (int n = 0; n < int'(NPIX); n++) exp_pix.push_back(base + 32'(n * 4));
    done_before = done_cnt;
    frame_base = base;
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    check_val("busy_after_start", 64'(busy), 64'd1);
    check_val("underflow_clr_on_start", 64'(underflow), 64'd0);
  endtask

  task automatic wait_done(input bit start_on_done);
    int t;
    t = 0;
    while (frame_done !== 1'b1 && t < TMO) begin
      @(negedge ACLK);
      t++;
    end
    if (t >= TMO) begin
      check_val("frame_timeout", 64'(t), 64'd0);
      return;
    end
    check_val("busy_low_at_done", 64'(busy), 64'd0);
    if (start_on_done) begin
      frame_base = 32'hDEAD_0000;
      start = 1'b1;
    end
    @(negedge ACLK);
    start = 1'b0;
    check_val("done_single_cycle", 64'(frame_done), 64'd0);
    if (start_on_done) check_val("start_on_done_ignored", 64'(busy), 64'd0);
    repeat (5) @(negedge ACLK);
    check_val("pix_all_seen", 64'(exp_pix.size()), 64'd0);
    check_val("addr_all_seen", 64'(exp_addr.size()), 64'd0);
    check_val("done_pulse_count", 64'(done_cnt - done_before), 64'd1);
  endtask

  initial begin : main
    int bb;
    int rb;
    int b0;
    int t;
    int rf;
    main_rstn = 1'b0;
    start = 1'b0;
    frame_base = '0;
    repeat (3) @(negedge ACLK);
    check_val("rst_bde_req", 64'(bde_req), 64'd0);
    check_val("rst_bde_arlen", 64'(bde_arlen), 64'd0);
    check_val("rst_bde_address", 64'(bde_address), 64'd0);
    check_val("rst_pix_valid", 64'(pix_valid), 64'd0);
    check_val("rst_pix_data", 64'(pix_data), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_frame_done", 64'(frame_done), 64'd0);
    check_val("rst_underflow", 64'(underflow), 64'd0);
    main_rstn = 1'b1;
    repeat (2) @(negedge ACLK);

    // Basic frame, ready always high; latency from first beat to pix_valid
    ready_mode = 0;
    bb = beat0_cyc.size();
    rb = rise_cyc.size();
    do_start(32'h1000_0000);
    wait_done(1'b1);
    if (beat0_cyc.size() > bb && rise_cyc.size() > rb)
      check_val("first_pix_latency", 64'(rise_cyc[rb] - beat0_cyc[bb]), 64'd2);
    else
      check_val("latency_samples", 64'(rise_cyc.size() - rb), 64'd1);
    check_val("no_req_after_ignored_start", 64'(bde_req), 64'd0);

    // Consumer stalled: bursts limited by FIFO space
    ready_mode = 1;
    b0 = bursts_seen;
    do_start(32'h3000_0000);
    repeat (200) @(negedge ACLK);
    check_val("bursts_while_stalled", 64'(bursts_seen - b0), 64'(FD / BB));
    check_val("no_ovf_while_stalled", 64'(dut.ovf_err), 64'd0);
    check_val("req_low_while_full", 64'(bde_req), 64'd0);
    ready_mode = 0;
    wait_done(1'b0);
    check_val("bursts_per_frame", 64'(bursts_seen - b0), 64'(NBURST));

    // Ready toggling every cycle
    ready_mode = 2;
    do_start(32'h4000_0000);
    wait_done(1'b0);

    // Address wrap at the top of the 32-bit space, random ready
    ready_mode = 3;
    do_start(32'hFFFF_FF80);
    wait_done(1'b0);

    // Reset during beat 5 of the first burst, then a fresh frame
    ready_mode = 0;
    rf = rst_fired;
    rst_arm = 1'b1;
    do_start(32'h5000_0000);
    t = 0;
    while (rst_fired == rf && t < TMO) begin
      @(negedge ACLK);
      t++;
    end
    check_val("reset_fired", 64'(rst_fired - rf), 64'd1);
    rst_arm = 1'b0;
    repeat (2) @(negedge ACLK);
    exp_pix.delete();
    exp_addr.delete();
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_pix_valid", 64'(pix_valid), 64'd0);
    check_val("midrst_bde_req", 64'(bde_req), 64'd0);
    do_start(32'h6000_0000);
    wait_done(1'b0);

    // Beat gaps starve the consumer: underflow sticks until the next start
    gap = 2;
    ready_mode = 0;
    do_start(32'h7000_0000);
    wait_done(1'b0);
    check_val("underflow_set", 64'(underflow), 64'd1);
    repeat (10) @(negedge ACLK);
    check_val("underflow_sticky", 64'(underflow), 64'd1);
    gap = 0;
    do_start(32'h8000_0000);
    wait_done(1'b0);
    check_val("no_ovf_overall", 64'(dut.ovf_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
